mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single synchronous-read memory port between two masters: req 0 = instruction
//   fetch, req 1 = load/store unit, or two cores. Sequences each access into one memory
//   transaction (address / write phase, read-latency wait, one-cycle ack). Arbitrates
//   round-robin or fixed-priority when both masters request at once.
// PARAMETERS
//   ADDR_W   32  address width, passed through untranslated
//   DATA_W   32  data width
//   MEM_LAT  1   memory read latency in cycles (>=1); data valid MEM_LAT cycles after address
//   FIXED_PRI 0  0 = round-robin; 1 = requester 0 always wins ties
// PORTS
//   clk           in   1       clock, rising edge
//   resetn        in   1       synchronous, active-low reset
//   req_i         in   2       per-requester request, held high until ack
//   we_i          in   2       per-requester write enable (1 = store)
//   addr0_i       in   ADDR_W  requester 0 address
//   addr1_i       in   ADDR_W  requester 1 address
//   wdata0_i      in   DATA_W  requester 0 write data
//   wdata1_i      in   DATA_W  requester 1 write data
//   gnt_o         out  2       one-hot owner of the current transaction, 0 when idle
//   ack_o         out  2       one-cycle completion pulse to the owner
//   rdata_o       out  DATA_W  read data, valid in the ack cycle, held until next ack
//   mem_address   out  ADDR_W  memory address
//   mem_data_out  out  DATA_W  memory write data
//   mem_data_in   in   DATA_W  memory read data
//   mem_we        out  1       memory write enable
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; round-robin pointer favours requester 0.
//   Reset mid-transaction: aborts at that edge. No ack; mem_we 0 in the next cycle.
//   FSM (all outputs registered):
//   - IDLE: if req_i != 0, pick winner, latch its addr/wdata/we onto the mem_* outputs,
//     set gnt_o, go to ACCESS.
//   - ACCESS: exactly 1 cycle. mem_we = latched we, asserted this cycle only.
//     Go to WAIT; load the latency counter with MEM_LAT-1.
//   - WAIT: MEM_LAT cycles; mem_address/mem_data_out held, mem_we 0. On the last cycle,
//     sample mem_data_in into rdata_o (reads only; writes leave rdata_o unchanged),
//     set ack_o[owner], go to ACK.
//   - ACK: ack_o pulses for this single cycle. Clear gnt_o and ack_o; go to IDLE.
//     The round-robin pointer moves to the non-owner.
//   Latency: req seen in cycle t -> ack in cycle t+2+MEM_LAT. That is t+3 at the default.
//   One transaction in flight at a time. The IDLE cycle after ACK is mandatory, so a
//   requester that drops req on the ack edge is never re-granted.
//   Tie (req_i==2'b11): FIXED_PRI=1 -> 0 wins. Round-robin -> the requester not served
//     last wins. Alternation holds under continuous dual requests.
//   Req dropped after grant: the transaction still completes and ack still pulses.
//     Inputs are not re-sampled after IDLE.
//   mem_address and mem_data_out keep their last value in IDLE; mem_we is 0 outside ACCESS.
//   Counter width: $clog2(MEM_LAT+1). MEM_LAT=1 gives a single WAIT cycle, no wrap.
// STRUCTURE
//   Package mem_arb_pkg: state encoding (IDLE, ACCESS, WAIT, ACK) and a 2-bit one-hot
//     requester ID constant set.
//   Sub-module rr_pick2: combinational winner select from req_i and pointer, plus the
//     pointer register, with an update strobe driven from ACK.
//   FSM, latency counter and mem_* registers stay in mem_port_arbiter.
// TESTING
//   1. Single read: req_i=01, addr0=0x10, memory word 0x10 = 0xDEADBEEF, MEM_LAT=1
//      -> mem_address=0x10 in cycle t+1, ack_o=01 in t+3, rdata_o=0xDEADBEEF,
//      mem_we never set.
//   2. Single write: req_i=10, we_i=10, addr1=0x20, wdata1=0x5
//      -> mem_we=1 for exactly one cycle with mem_data_out=0x5; ack_o=10 at t+3;
//      readback of 0x20 = 0x5.
//   3. Tie, round-robin: req_i=11 held for 4 transactions -> grant order 0,1,0,1;
//      each ack 4 cycles apart.
//   4. Tie, FIXED_PRI=1: req_i=11 -> requester 0 served first; requester 1 is served only
//      after req0 drops.
//   5. Reset mid-WAIT with MEM_LAT=3 -> next cycle: gnt_o=0, ack_o=0, mem_we=0, state IDLE;
//      a fresh req0 completes normally.
//   6. Req dropped in ACCESS -> ack still pulses at t+2+MEM_LAT; the pointer still advances.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-master memory port arbiter: FSM state codes
// and one-hot requester IDs.
package mem_arb_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_0    = 2'b01;
  localparam logic [1:0] REQ_1    = 2'b10;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: registered address/write data/write enable
// out, synchronous read data back in.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_we;

  modport master (output mem_address, mem_data_out, mem_we, input mem_data_in);
  modport slave  (input mem_address, mem_data_out, mem_we, output mem_data_in);
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way winner select (round-robin or fixed priority) plus the pointer that
// remembers which requester is favoured on the next tie.
module rr_pick2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       owner1_i,
  output logic [1:0] win_o
);
  logic ptr_q, ptr_d;  // 1 = requester 1 wins the next tie

  always_comb begin
    win_o = REQ_NONE;
    if (req_i == 2'b11)  win_o = (!FIXED_PRI && ptr_q) ? REQ_1 : REQ_0;
    else if (req_i[0])   win_o = REQ_0;
    else if (req_i[1])   win_o = REQ_1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = !owner1_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between two masters, one
// transaction at a time: ACCESS, MEM_LAT wait cycles, one-cycle ACK, IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        ack_o,
  output logic [DATA_W-1:0] rdata_o,
  mem_port_arbiter_if.master mem
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d, ack_q, ack_d, win;
  logic              wr_q, wr_d, mem_we_q, mem_we_d, upd;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

  rr_pick2 #(.FIXED_PRI(FIXED_PRI)) u_pick (
    .clk(clk), .resetn(resetn), .req_i(req_i),
    .upd_i(upd), .owner1_i(gnt_q[1]), .win_o(win)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    wr_d     = wr_q;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    upd      = 1'b0;
    case (state_q)
      S_IDLE: if (win != REQ_NONE) begin
        gnt_d    = win;
        wr_d     = |(we_i & win);
        mem_we_d = |(we_i & win);
        addr_d   = win[1] ? addr1_i  : addr0_i;
        wdata_d  = win[1] ? wdata1_i : wdata0_i;
        state_d  = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q == '0) begin
        // Read data is valid MEM_LAT cycles after the address went out.
        if (!wr_q) rdata_d = mem.mem_data_in;
        ack_d   = gnt_q;
        state_d = S_ACK;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      S_ACK: begin
        gnt_d   = REQ_NONE;
        ack_d   = REQ_NONE;
        upd     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      wr_q     <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      wr_q     <= wr_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt_o            = gnt_q;
  assign ack_o            = ack_q;
  assign rdata_o          = rdata_q;
  assign mem.mem_address  = addr_q;
  assign mem.mem_data_out = wdata_q;
  assign mem.mem_we       = mem_we_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations (LAT1/RR, LAT3/RR, LAT2/fixed),
// directed scenarios then random traffic against a transaction-timeline model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int c);
    return (c == 1) ? 3 : (c == 2) ? 2 : 1;
  endfunction
  function automatic bit fp_of(input int c);
    return c == 2;
  endfunction
  function automatic logic [31:0] init_word(input int i);
    return 32'hDEADBEEF ^ (32'(i) ^ 32'h10);
  endfunction

  logic [1:0]  req [3], we [3], gnt [3], ack [3];
  logic [31:0] a0 [3], a1 [3], w0 [3], w1 [3], rd [3], maddr [3], mdo [3];
  logic        mwe [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int L = lat_of(gi);
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .FIXED_PRI(fp_of(gi))) dut (
      .clk(clk), .resetn(resetn), .req_i(req[gi]), .we_i(we[gi]),
      .addr0_i(a0[gi]), .addr1_i(a1[gi]), .wdata0_i(w0[gi]), .wdata1_i(w1[gi]),
      .gnt_o(gnt[gi]), .ack_o(ack[gi]), .rdata_o(rd[gi]), .mem(mif)
    );
    logic [31:0] mem [32];
    logic [31:0] pipe [L];
    always @(posedge clk) begin
      if (!resetn) for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      else if (mif.mem_we) mem[mif.mem_address[4:0]] <= mif.mem_data_out;
      pipe[0] <= mem[mif.mem_address[4:0]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mif.mem_data_in = pipe[L-1];
    assign maddr[gi] = mif.mem_address;
    assign mdo[gi]   = mif.mem_data_out;
    assign mwe[gi]   = mif.mem_we;
  end

  int checks = 0, errors = 0, cyc = 0, k = 0, mwe_cnt = 0, t0 = 0;
  // transaction timeline model
  bit          have, last1, t_we;
  int          t_st;
  logic [1:0]  t_own, cur_ack;
  logic [31:0] t_addr, t_wd, t_rd, e_addr, e_wd, e_rd;
  logic [31:0] shadow [32];
  // requester drive state
  logic [1:0]  r_req, r_we;
  logic [31:0] r_a [2], r_w [2];
  bit [1:0]    granted, keep;
  int          ack_own [$], ack_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d cfg %0d)", tag, obs, exp, cyc, k);
    end
  endtask

  task automatic tick();
    int L;
    logic [1:0] eg;
    bit ew;
    @(negedge clk);
    cyc++;
    L  = lat_of(k);
    eg = (have && cyc > t_st && cyc <= t_st + 2 + L) ? t_own : 2'b00;
    cur_ack = (have && cyc == t_st + 2 + L) ? t_own : 2'b00;
    ew = have && t_we && cyc == t_st + 1;
    if (cur_ack != 2'b00 && !t_we) e_rd = t_rd;
    chk("gnt_o",        32'(gnt[k]), 32'(eg));
    chk("ack_o",        32'(ack[k]), 32'(cur_ack));
    chk("mem_we",       32'(mwe[k]), 32'(ew));
    chk("rdata_o",      rd[k],       e_rd);
    chk("mem_address",  maddr[k],    e_addr);
    chk("mem_data_out", mdo[k],      e_wd);
    if (mwe[k]) mwe_cnt++;
    if (ack[k] != 2'b00) begin
      ack_own.push_back(int'(ack[k][1]));
      ack_cyc.push_back(cyc);
    end
  endtask

  task automatic apply();
    logic [1:0] w;
    req[k] = r_req; we[k] = r_we;
    a0[k] = r_a[0]; a1[k] = r_a[1]; w0[k] = r_w[0]; w1[k] = r_w[1];
    if (resetn && (!have || cyc >= t_st + 3 + lat_of(k)) && r_req != 2'b00) begin
      if (r_req == 2'b11) w = (fp_of(k) || last1) ? 2'b01 : 2'b10;
      else                w = r_req;
      have = 1'b1; t_st = cyc; t_own = w; last1 = w[1]; granted[w[1]] = 1'b1;
      t_we   = r_we[w[1]];
      t_addr = r_a[w[1]];
      t_wd   = r_w[w[1]];
      t_rd   = shadow[t_addr[4:0]];
      if (t_we) shadow[t_addr[4:0]] = t_wd;
      e_addr = t_addr; e_wd = t_wd;
    end
  endtask

  task automatic pol(input bit rnd);
    for (int r = 0; r < 2; r++) begin
      if (cur_ack[r]) begin
        granted[r] = 1'b0;
        if (rnd || !keep[r]) r_req[r] = 1'b0;
      end else if (rnd && !r_req[r] && !granted[r]) begin
        if ($urandom_range(2) == 0) begin
          r_req[r] = 1'b1; r_we[r] = 1'($urandom_range(1));
          r_a[r] = $urandom; r_w[r] = $urandom;
        end
      end else if (rnd && r_req[r] && granted[r] && $urandom_range(3) == 0) begin
        r_req[r] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      tick(); pol(rnd); apply();
    end
  endtask

  task automatic clr_log();
    ack_own.delete(); ack_cyc.delete(); mwe_cnt = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    have = 1'b0; t_st = 0; last1 = 1'b1; cur_ack = '0;
    e_addr = '0; e_wd = '0; e_rd = '0;
    for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
    r_req = '0; r_we = '0; granted = '0; keep = '0;
    apply();
    tick();
    resetn = 1'b1;
    clr_log();
  endtask

  initial begin
    for (int c = 0; c < 3; c++) begin
      req[c] = '0; we[c] = '0; a0[c] = '0; a1[c] = '0; w0[c] = '0; w1[c] = '0;
    end
    for (int r = 0; r < 2; r++) begin r_a[r] = '0; r_w[r] = '0; end

    // single read of the preloaded word
    k = 0; do_reset();
    r_req = 2'b01; r_a[0] = 32'h10; apply(); t0 = cyc;
    run(6, 1'b0);
    chk("t1_acks", ack_own.size(), 1);
    chk("t1_latency", ack_cyc[0] - t0, 3);
    chk("t1_rdata", rd[0], 32'hDEADBEEF);
    chk("t1_no_we", mwe_cnt, 0);

    // single write by requester 1, then read it back
    clr_log();
    r_req = 2'b10; r_we = 2'b10; r_a[1] = 32'h20; r_w[1] = 32'h5; apply(); t0 = cyc;
    run(6, 1'b0);
    chk("t2_ack_owner", ack_own[0], 1);
    chk("t2_latency", ack_cyc[0] - t0, 3);
    chk("t2_we_cycles", mwe_cnt, 1);
    r_req = 2'b01; r_we = 2'b00; r_a[0] = 32'h20; apply();
    run(6, 1'b0);
    chk("t2_readback", rd[0], 32'h5);

    // continuous tie under round-robin alternates
    do_reset();
    keep = 2'b11; r_req = 2'b11; r_a[0] = 32'h3; r_a[1] = 32'h7; apply();
    run(16, 1'b0);
    chk("t3_acks", ack_own.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", ack_own[i], i % 2);
    for (int i = 1; i < 4; i++) chk("t3_spacing", ack_cyc[i] - ack_cyc[i-1], 4);

    // fixed priority starves requester 1 while requester 0 keeps asking
    k = 2; do_reset();
    keep = 2'b11; r_req = 2'b11; r_a[0] = 32'h1; r_a[1] = 32'h2; apply();
    run(10, 1'b0);
    keep[0] = 1'b0;
    run(10, 1'b0);
    chk("t4_acks", ack_own.size(), 4);
    for (int i = 0; i < 3; i++) chk("t4_order0", ack_own[i], 0);
    chk("t4_order1", ack_own[3], 1);

    // reset in the middle of a WAIT, then a fresh read completes
    k = 1; do_reset();
    r_req = 2'b01; r_a[0] = 32'h10; apply();
    run(2, 1'b0);
    do_reset();
    chk("t5_gnt_idle", 32'(gnt[1]), 32'h0);
    r_req = 2'b01; r_a[0] = 32'h4; apply(); t0 = cyc;
    run(8, 1'b0);
    chk("t5_acks", ack_own.size(), 1);
    chk("t5_latency", ack_cyc[0] - t0, 5);
    chk("t5_rdata", rd[1], init_word(4));

    // request withdrawn during ACCESS: ack still pulses, pointer still moves
    k = 0; do_reset();
    r_req = 2'b01; r_a[0] = 32'h9; apply(); t0 = cyc;
    tick(); r_req = 2'b00; apply();
    run(4, 1'b0);
    chk("t6_acks", ack_own.size(), 1);
    chk("t6_latency", ack_cyc[0] - t0, 3);
    clr_log();
    r_req = 2'b11; apply();
    run(8, 1'b0);
    chk("t6_next_owner", ack_own[0], 1);

    // random traffic on every configuration
    for (int c = 0; c < 3; c++) begin
      k = c; do_reset();
      run(400, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
